// File: rtl/shift_rx_pkg.sv
// Shared types and constants for the shift-register link receiver.
package shift_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/rx_shift_stage.sv
// Assembly register, direction-latched shifter and bit counter for one serial word.
// NBITS counts every serial bit of a word, data plus any trailing parity bit.
module rx_shift_stage
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NBITS = WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             accept,
  input  logic             ser_in,
  input  logic             dir,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(NBITS + 1);

  logic [WIDTH-1:0] asm_q, asm_base, asm_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_nxt;
  logic             dir_q, dir_eff;

  // A restart discards the partial word before this cycle's bit is considered.
  always_comb begin
    asm_base = start ? '0 : asm_q;
    cnt_base = start ? '0 : cnt_q;
    dir_eff  = (cnt_base == '0) ? dir : dir_q;
    asm_nxt  = asm_base;
    cnt_nxt  = cnt_base;
    done     = 1'b0;
    if (accept) begin
      if (cnt_base < CNT_W'(WIDTH)) begin
        if (dir_eff == DIR_LSB_FIRST) asm_nxt = {ser_in, asm_base[WIDTH-1:1]};
        else                          asm_nxt = {asm_base[WIDTH-2:0], ser_in};
      end
      if (cnt_base == CNT_W'(NBITS - 1)) begin
        done    = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt_base + 1'b1;
      end
    end
  end

  // The completed word is taken from asm_nxt on the completing edge.
  assign word = asm_nxt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      asm_q <= '0;
      cnt_q <= '0;
      dir_q <= DIR_MSB_FIRST;
      busy  <= 1'b0;
    end else begin
      asm_q <= done ? '0 : asm_nxt;
      cnt_q <= cnt_nxt;
      busy  <= (cnt_nxt != '0);
      if (accept && (cnt_base == '0)) dir_q <= dir;
    end
  end

endmodule

// File: rtl/shift_word_receiver.sv
// Serial-to-parallel word receiver with one-word output buffer and sticky overrun.
// Optional trailing even-parity bit per word: define SHIFT_RX_PARITY_EN.
module shift_word_receiver
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             dir,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             par_err,
  output logic             overrun,
  output logic             busy
);

`ifdef SHIFT_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  state_t           state_q, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             err_nxt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    if (frame_start) state_nxt = RECV;
    accept = ser_valid && (frame_start || (state_q == RECV));
  end

  rx_shift_stage #(
    .WIDTH (WIDTH),
    .NBITS (WIDTH + PAR_BITS)
  ) u_stage (
    .clk    (clk),
    .clear  (clear),
    .start  (frame_start),
    .accept (accept),
    .ser_in (ser_in),
    .dir    (dir),
    .word   (word),
    .done   (done),
    .busy   (busy)
  );

  // On completion with parity the current serial bit is the parity bit.
`ifdef SHIFT_RX_PARITY_EN
  assign err_nxt = (^word) ^ ser_in;
`else
  assign err_nxt = 1'b0;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      par_out   <= '0;
      par_valid <= 1'b0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      if (!par_valid || par_ready) begin
        par_out   <= word;
        par_err   <= err_nxt;
        par_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (par_valid && par_ready) begin
      par_valid <= 1'b0;
    end
  end

endmodule
